fp_int_mul_lanes: RTL and testbench
===================================

// Module: fp_int_mul_lanes
// PURPOSE
//  Bit-serial FP16 x signed-INT multiplier that broadcasts one FP16 activation to LANES packed weights.
//  Each lane produces sign, shared raw exponent and an unnormalised fixed-point product mantissa.
//  Sits in the FP-INT MAC datapath ahead of the accumulator/aligner.
//  Generalises the single-lane unsigned-INT4 multiplier to:
//   - signed weights of any width;
//   - multiple lanes;
//   - subnormal activations.
// PARAMETERS
//  ACT_WIDTH  16  activation width; FP16 only (1 sign, 5 exponent, 10 fraction bits)
//  W_WIDTH    4   weight width, two's complement, legal range 2..8
//  LANES      4   number of weight lanes sharing the activation, 1..16
//  MAN_WIDTH  11+W_WIDTH  product mantissa width per lane (derived; do not override)
// PORTS
//  clk           in   1                  clock, rising edge
//  rst           in   1                  asynchronous active-low reset
//  activation    in   ACT_WIDTH          FP16 operand, sampled on the accepted start
//  weight        in   LANES*W_WIDTH      packed signed weights; lane i = [i*W_WIDTH +: W_WIDTH]
//  start         in   1                  request; accepted only when busy==0
//  busy          out  1                  operation in progress
//  sign_out      out  LANES              per-lane product sign
//  exp_out       out  5                  activation exponent field, passed through unchanged
//  mantissa_out  out  LANES*MAN_WIDTH    per-lane significand*|weight|, unsigned
//  done          out  1                  result valid; level signal, held until the next accepted start
// BEHAVIOUR
//  Reset (rst==0, asynchronous): state=IDLE; busy, done, sign_out, exp_out and mantissa_out are all 0.
//  Reset mid-operation aborts the operation; no partial result is kept.
//  FSM states:
//   IDLE: start&&!busy at edge E0 does the following:
//    - latch activation and weights;
//    - compute per-lane |w| (W_WIDTH bits; -2^(W_WIDTH-1) gives magnitude 2^(W_WIDTH-1));
//    - clear the accumulators and set cnt=0;
//    - busy=1, done=0; go to MUL.
//   MUL: each edge, for every lane, acc += mag[cnt] ? (sig << cnt) : 0; then cnt++.
//    - On the edge processing cnt==W_WIDTH-1: go to IDLE, busy=0, done=1;
//      mantissa_out/sign_out/exp_out are loaded from the final accumulators in that same edge.
//  Latency: done=1 and busy=0 after edge E_W (W_WIDTH edges after E0).
//  Outputs are registered and stable while done==1.
//  Arithmetic rules:
//   - sig = {exp!=0, frac[9:0]}: hidden bit 0 for subnormals.
//   - sign_out[i] = act_sign ^ w_sign[i]. For w==0, mantissa is 0 and sign = act_sign.
//   - No normalisation, rounding or overflow: MAN_WIDTH holds the maximum product exactly.
//   - exp==31 (Inf/NaN) is not special-cased; exponent and computed mantissa pass through.
//  Boundary cases:
//   - start while busy: ignored; inputs are not re-sampled.
//   - start with done==1: accepted normally; done drops at E0.
//   - Changing activation/weight while busy: no effect.
// CONFIGURATION
//  `ZERO_SKIP_EN` defined:
//   - In MUL, if every lane's magnitude bits above cnt are 0, finish on the current edge
//     (minimum 1 MUL edge).
//   - Latency = 1 + index of the highest set magnitude bit over all lanes (1 when all weights are 0).
//   - Results are bit-identical to the non-skip build.
//  Not defined: fixed latency of W_WIDTH edges for every operation.
// TESTING
//  1. LANES=1, W=4, act=16'hC1A9, w=4'b0110, start sampled at E0
//     -> at E4: sign_out=1, exp_out=5'b10000, mantissa_out=15'b010000111110110, done=1, busy=0.
//  2. act=16'h3C00 (1.0), w=4'b1000 (-8)
//     -> sign_out=1, exp_out=5'b01111, mantissa_out=15'b010000000000000.
//  3. LANES=4, act=16'h0001 (subnormal), w={4'd7, 4'hF, 4'd0, 4'd1}
//     -> lanes3..0: mantissa {7, 1, 0, 1}; sign {0, 1, 0, 0}; exp_out=0.
//  4. Pulse start again at E1 and E2 while busy with different inputs
//     -> ignored; result equals test 1; done first rises at E4.
//  5. rst=0 between E2 and E3 of an operation
//     -> all outputs 0 immediately. After release, a new start completes normally with correct results.
//  6. ZERO_SKIP_EN, w=4'b0001 -> done at E1. Without the macro -> done at E4. Both give mantissa_out=1449.

Source files
------------

// File: rtl/fp_int_mul_lanes.sv
// Bit-serial FP16 x signed-INT multiplier: one FP16 activation broadcast to LANES weights.
// Optional `ZERO_SKIP_EN ends the multiply once no lane has magnitude bits left above cnt.
module fp_int_mul_lane #(
    parameter int W_WIDTH   = 4,
    parameter int MAN_WIDTH = 11 + W_WIDTH,
    parameter int CW        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic [W_WIDTH-1:0]   w,
    input  logic [10:0]          sig,
    input  logic [CW-1:0]        cnt,
    input  logic                 act_sign,
`ifdef ZERO_SKIP_EN
    output logic                 hi_zero,
`endif
    output logic                 sign_out,
    output logic [MAN_WIDTH-1:0] mantissa_out
);
    logic [W_WIDTH-1:0]   mag;
    logic [W_WIDTH-1:0]   w_abs;
    logic                 w_sign;
    logic [MAN_WIDTH-1:0] acc;
    logic [MAN_WIDTH-1:0] acc_nxt;

    // the most negative weight maps to 2^(W_WIDTH-1), which still fits unsigned
    assign w_abs   = w[W_WIDTH-1] ? (~w + 1'b1) : w;
    assign acc_nxt = acc + (mag[cnt] ? (MAN_WIDTH'(sig) << cnt) : '0);
`ifdef ZERO_SKIP_EN
    assign hi_zero = ((mag >> cnt) >> 1) == '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag          <= '0;
            w_sign       <= 1'b0;
            acc          <= '0;
            sign_out     <= 1'b0;
            mantissa_out <= '0;
        end else if (load) begin
            mag    <= w_abs;
            w_sign <= w[W_WIDTH-1];
            acc    <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            if (finish) begin
                mantissa_out <= acc_nxt;
                sign_out     <= act_sign ^ w_sign;
            end
        end
    end
endmodule

module fp_int_mul_lanes #(
    parameter int ACT_WIDTH = 16,
    parameter int W_WIDTH   = 4,
    parameter int LANES     = 4,
    parameter int MAN_WIDTH = 11 + W_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ACT_WIDTH-1:0]         activation,
    input  logic [LANES*W_WIDTH-1:0]     weight,
    input  logic                         start,
    output logic                         busy,
    output logic [LANES-1:0]             sign_out,
    output logic [4:0]                   exp_out,
    output logic [LANES*MAN_WIDTH-1:0]   mantissa_out,
    output logic                         done
);
    localparam int CW = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W_WIDTH - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [10:0] sig;
    } act_t;

    logic [0:0]                         state;
    logic [CW-1:0]                      cnt;
    act_t                               act;
    act_t                               act_dec;
    logic                               load;
    logic                               step;
    logic                               fin;
    logic [LANES-1:0][MAN_WIDTH-1:0]    lane_man;
    logic [LANES-1:0][W_WIDTH-1:0]      lane_w;

    // hidden bit is 0 for subnormals (exp==0); Inf/NaN are not special-cased
    assign act_dec.sign = activation[15];
    assign act_dec.exp  = activation[14:10];
    assign act_dec.sig  = {activation[14:10] != 5'd0, activation[9:0]};

    assign busy   = (state == S_MUL);
    assign load   = (state == S_IDLE) && start;
    assign step   = (state == S_MUL);
    assign lane_w = weight;
    assign mantissa_out = lane_man;

`ifdef ZERO_SKIP_EN
    logic [LANES-1:0] hi_zero;
    assign fin = (cnt == CNT_LAST) || (&hi_zero);
`else
    assign fin = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            act     <= '0;
            done    <= 1'b0;
            exp_out <= 5'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    act   <= act_dec;
                    cnt   <= '0;
                    done  <= 1'b0;
                    state <= S_MUL;
                end
                default: begin
                    cnt <= cnt + 1'b1;
                    if (fin) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        exp_out <= act.exp;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_int_mul_lane #(
            .W_WIDTH   (W_WIDTH),
            .MAN_WIDTH (MAN_WIDTH),
            .CW        (CW)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .load         (load),
            .step         (step),
            .finish       (fin),
            .w            (lane_w[i]),
            .sig          (act.sig),
            .cnt          (cnt),
            .act_sign     (act.sign),
`ifdef ZERO_SKIP_EN
            .hi_zero      (hi_zero[i]),
`endif
            .sign_out     (sign_out[i]),
            .mantissa_out (lane_man[i])
        );
    end
endmodule

// File: tb/tb_fp_int_mul_lanes.sv
// Directed + random bench for fp_int_mul_lanes (LANES=4, W_WIDTH=4) against an arithmetic model.
module tb_fp_int_mul_lanes;
    localparam int L = 4;
    localparam int W = 4;
    localparam int M = 11 + W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      activation = '0;
    logic [L*W-1:0]   weight = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [L-1:0]     sign_out;
    logic [4:0]       exp_out;
    logic [L*M-1:0]   mantissa_out;
    logic             done;

    int vectors = 0;
    int miscompares = 0;

    logic [L*M-1:0] exp_man;
    logic [L-1:0]   exp_sgn;
    int             exp_lat;

    fp_int_mul_lanes dut (
        .clk(clk), .rst(rst), .activation(activation), .weight(weight), .start(start),
        .busy(busy), .sign_out(sign_out), .exp_out(exp_out), .mantissa_out(mantissa_out),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference: significand times |w| per lane, computed with plain integers
    task automatic model(input logic [15:0] a, input logic [L*W-1:0] wv);
        int sig, wi, mag, top;
        logic [W-1:0] wb;
        sig = (a[14:10] != 0 ? 1024 : 0) + int'(a[9:0]);
        exp_man = '0;
        exp_sgn = '0;
        top = -1;
        for (int i = 0; i < L; i++) begin
            wb  = wv[i*W +: W];
            wi  = wb[W-1] ? int'(wb) - (1 << W) : int'(wb);
            mag = wi < 0 ? -wi : wi;
            exp_man[i*M +: M] = M'(sig * mag);
            exp_sgn[i] = a[15] ^ (wi < 0);
            for (int b = 0; b < W; b++) if (mag[b]) top = (b > top) ? b : top;
        end
`ifdef ZERO_SKIP_EN
        exp_lat = (top < 0) ? 1 : top + 1;
`else
        exp_lat = W;
`endif
    endtask

    // one operation; optionally hammer start with junk inputs while busy
    task automatic do_op(input string tag, input logic [15:0] a, input logic [L*W-1:0] wv,
                         input bit junk);
        int lat;
        logic [L*M-1:0] man_hold;
        model(a, wv);
        @(negedge clk);
        activation = a; weight = wv; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".busy_e0"}, 64'(busy), 64'd1);
        chk({tag, ".done_e0"}, 64'(done), 64'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            if (junk && (lat + 1) < exp_lat) begin
                start = 1'b1; activation = 16'($urandom); weight = (L*W)'($urandom);
            end else begin
                start = 1'b0; activation = 16'($urandom); weight = (L*W)'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".sign"}, 64'(sign_out), 64'(exp_sgn));
        chk({tag, ".exp"}, 64'(exp_out), 64'(a[14:10]));
        chk({tag, ".man"}, 64'(mantissa_out), 64'(exp_man));
        man_hold = mantissa_out;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".hold_done"}, 64'(done), 64'd1);
        chk({tag, ".hold_man"}, 64'(mantissa_out), 64'(exp_man));
    endtask

    initial begin
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.man", 64'(mantissa_out), 64'd0);
        chk("reset.sign", 64'(sign_out), 64'd0);
        chk("reset.exp", 64'(exp_out), 64'd0);
        #12 rst = 1'b1;

        do_op("t1", 16'hC1A9, 16'h0006, 1'b0);
        chk("t1.lane0", 64'(mantissa_out[M-1:0]), 64'h21F6);
        do_op("t2", 16'h3C00, 16'h0008, 1'b0);
        chk("t2.lane0", 64'(mantissa_out[M-1:0]), 64'h2000);
        do_op("t3", 16'h0001, 16'h7F01, 1'b0);
        chk("t3.sign", 64'(sign_out), 64'b0100);
        do_op("t4", 16'hC1A9, 16'h0006, 1'b1);
        chk("t4.lane0", 64'(mantissa_out[M-1:0]), 64'h21F6);
        do_op("t6", 16'hC1A9, 16'h0001, 1'b0);
        chk("t6.lane0", 64'(mantissa_out[M-1:0]), 64'd1449);
        do_op("zero_w", 16'hBC00, 16'h0000, 1'b0);
        do_op("inf", 16'h7C00, 16'h8F81, 1'b0);

        // reset between E2 and E3; lane 3 weight -8 keeps the op running to E4 either build
        @(negedge clk);
        activation = 16'h4321; weight = 16'h8765; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.man", 64'(mantissa_out), 64'd0);
        chk("midrst.sign", 64'(sign_out), 64'd0);
        chk("midrst.exp", 64'(exp_out), 64'd0);
        @(negedge clk) rst = 1'b1;
        do_op("postrst", 16'h4321, 16'h8765, 1'b0);

        for (int n = 0; n < 30; n++)
            do_op("rand", 16'($urandom), (L*W)'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
